// File: rtl/pr_read_arbiter.sv
// ---------------------------------------------------------------------------
// pr_read_arbiter
//
// Purpose:
//   Shares one AXI read channel (AR/R) between NUM_REQ PageRank fetch engines
//   (req 0 = vertex fetcher, req 1 = in-edge fetcher). Requests are granted
//   round-robin, and each granted burst is tagged with arid = requester index.
//   Returning R beats are routed back to their requester by rid_m. Each
//   requester may have at most MAX_OUTST bursts outstanding. Any malformed
//   response sets a sticky error flag.
//
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   req_arvalid_i   [N]          per-requester read request valid
//   req_araddr_i    [N*64]       request address, requester i at [64*i +: 64]
//   req_arlen_i     [N*8]        burst length-1, requester i at [8*i +: 8]
//   req_arready_o   [N]          request accepted this cycle (one-hot or zero)
//   resp_valid_o    [N]          R beat valid for requester i
//   resp_data_o     [512]        R beat data, shared by all requesters
//   resp_last_o                  last beat of the burst
//   resp_ready_i    [N]          requester i accepts the beat
//   arid_m_o, araddr_m_o, arlen_m_o, arsize_m_o, arvalid_m_o, arready_m_i
//                                AXI AR channel (arsize fixed at 64 bytes)
//   rid_m_i, rdata_m_i, rresp_m_i, rlast_m_i, rvalid_m_i, rready_m_o
//                                AXI R channel
//   err_o                        sticky error, cleared only by reset
// ---------------------------------------------------------------------------
module pr_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic [NUM_REQ-1:0]      req_arvalid_i,
  input  logic [NUM_REQ*64-1:0]   req_araddr_i,
  input  logic [NUM_REQ*8-1:0]    req_arlen_i,
  output logic [NUM_REQ-1:0]      req_arready_o,

  output logic [NUM_REQ-1:0]      resp_valid_o,
  output logic [511:0]            resp_data_o,
  output logic                    resp_last_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,

  output logic [15:0]             arid_m_o,
  output logic [63:0]             araddr_m_o,
  output logic [7:0]              arlen_m_o,
  output logic [2:0]              arsize_m_o,
  output logic                    arvalid_m_o,
  input  logic                    arready_m_i,

  input  logic [15:0]             rid_m_i,
  input  logic [511:0]            rdata_m_i,
  input  logic [1:0]              rresp_m_i,
  input  logic                    rlast_m_i,
  input  logic                    rvalid_m_i,
  output logic                    rready_m_o,

  output logic                    err_o
);

  localparam int         IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_OUTST_C = 8'(MAX_OUTST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e        state_q;
  logic [IW-1:0] rr_q;
  logic [7:0]    outst_q [NUM_REQ];
  logic          arvalid_q;
  logic [15:0]   arid_q;
  logic [63:0]   araddr_q;
  logic [7:0]    arlen_q;
  logic          err_q;

  // Next-state values
  logic [IW-1:0] rr_d;
  logic [7:0]    outst_d [NUM_REQ];
  logic          err_d;

  // -------------------------------------------------------------------------
  // Round-robin grant
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0] elig;
  logic               gnt_any;
  logic [IW-1:0]      gnt_idx;
  logic [IW:0]        scan_sum;
  logic               gnt;

  always_comb begin
    elig     = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_arvalid_i[i] && (outst_q[i] < MAX_OUTST_C);
    end
    // Walk offsets from the far end back toward rr_q so that the eligible
    // requester closest to the pointer is the last one written and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IW+1)'(NUM_REQ);
      end
      if (elig[scan_sum[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_sum[IW-1:0];
      end
    end
  end

  // Grants are only offered while no AR is pending, and never during reset.
  assign gnt = (state_q == ST_IDLE) && gnt_any && !rst_i;

  always_comb begin
    req_arready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arready_o[i] = gnt && (gnt_idx == IW'(i));
    end
  end

  // Select the granted requester's address and length.
  logic [63:0] sel_addr;
  logic [7:0]  sel_len;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr = req_araddr_i[64*i +: 64];
        sel_len  = req_arlen_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    if (gnt_idx == IW'(NUM_REQ - 1)) begin
      rr_d = '0;
    end else begin
      rr_d = gnt_idx + IW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // R channel routing
  // -------------------------------------------------------------------------
  logic          rid_ok;
  logic [IW-1:0] rid_idx;
  logic          r_hs;
  logic          last_hs;
  logic          dec_ok;
  logic          err_set;

  assign rid_ok  = (rid_m_i < 16'(NUM_REQ));
  assign rid_idx = rid_m_i[IW-1:0];

  always_comb begin
    resp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_o[i] = rvalid_m_i && rid_ok && (rid_idx == IW'(i));
    end
  end

  // Beats with an unknown id are swallowed so the interconnect never stalls.
  assign rready_m_o  = rid_ok ? resp_ready_i[rid_idx] : 1'b1;
  assign resp_data_o = rdata_m_i;
  assign resp_last_o = rlast_m_i;

  assign r_hs    = rvalid_m_i && rready_m_o;
  assign last_hs = r_hs && rlast_m_i && rid_ok;
  // A last beat for a requester with no credit in use (e.g. a burst issued
  // before reset) must not wrap the counter.
  assign dec_ok  = last_hs && (outst_q[rid_idx] != 8'd0);

  assign err_set = (r_hs && !rid_ok)
                || (r_hs && (rresp_m_i != 2'b00))
                || (last_hs && (outst_q[rid_idx] == 8'd0));

  assign err_d = err_q || err_set;

  // -------------------------------------------------------------------------
  // Credit counters
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      outst_d[i] = outst_q[i]
                 + {7'd0, (gnt && (gnt_idx == IW'(i)))}
                 - {7'd0, (dec_ok && (rid_idx == IW'(i)))};
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt) begin
            state_q   <= ST_ISSUE;
            arvalid_q <= 1'b1;
            arid_q    <= 16'(gnt_idx);
            araddr_q  <= sel_addr;
            arlen_q   <= sel_len;
            rr_q      <= rr_d;
          end
        end
        ST_ISSUE: begin
          // AR fields hold until the slave takes them.
          if (arready_m_i) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          arvalid_q <= 1'b0;
        end
      endcase
      for (int i = 0; i < NUM_REQ; i++) begin
        outst_q[i] <= outst_d[i];
      end
      err_q <= err_d;
    end
  end

  assign arvalid_m_o = arvalid_q;
  assign arid_m_o    = arid_q;
  assign araddr_m_o  = araddr_q;
  assign arlen_m_o   = arlen_q;
  assign arsize_m_o  = 3'b110;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pr_read_arbiter.sv
module tb_pr_read_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        req_arvalid;
  logic [N*64-1:0]     req_araddr;
  logic [N*8-1:0]      req_arlen;
  logic [N-1:0]        req_arready;
  logic [N-1:0]        resp_valid;
  logic [511:0]        resp_data;
  logic                resp_last;
  logic [N-1:0]        resp_ready;
  logic [15:0]         arid_m;
  logic [63:0]         araddr_m;
  logic [7:0]          arlen_m;
  logic [2:0]          arsize_m;
  logic                arvalid_m;
  logic                arready_m;
  logic [15:0]         rid_m;
  logic [511:0]        rdata_m;
  logic [1:0]          rresp_m;
  logic                rlast_m;
  logic                rvalid_m;
  logic                rready_m;
  logic                err;

  pr_read_arbiter #(.NUM_REQ(N), .MAX_OUTST(MAXO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_arvalid_i(req_arvalid),
    .req_araddr_i (req_araddr),
    .req_arlen_i  (req_arlen),
    .req_arready_o(req_arready),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_last_o  (resp_last),
    .resp_ready_i (resp_ready),
    .arid_m_o     (arid_m),
    .araddr_m_o   (araddr_m),
    .arlen_m_o    (arlen_m),
    .arsize_m_o   (arsize_m),
    .arvalid_m_o  (arvalid_m),
    .arready_m_i  (arready_m),
    .rid_m_i      (rid_m),
    .rdata_m_i    (rdata_m),
    .rresp_m_i    (rresp_m),
    .rlast_m_i    (rlast_m),
    .rvalid_m_i   (rvalid_m),
    .rready_m_o   (rready_m),
    .err_o        (err)
  );

  typedef struct {
    bit           chk;
    logic [N-1:0] arready;
    logic         arvalid;
    logic [15:0]  id;
    logic [63:0]  addr;
    logic [7:0]   len;
    logic [N-1:0] rvalid;
    logic         rready;
    logic [511:0] data;
    logic         last;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: credits, rr pointer, the one pending AR, sticky err.
  int          m_rr;
  int          m_outst[N];
  bit          m_pend;
  int          m_id;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  bit          m_err;
  int          iss0[$];
  int          iss1[$];
  bit          r_hs_last;
  int          n_grants[N];

  // R driver state
  bit r_act;
  int r_id;
  int r_left;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_rr   = 0;
    m_pend = 0;
    m_id   = 0;
    m_addr = '0;
    m_len  = '0;
    m_err  = 0;
    for (int i = 0; i < N; i++) m_outst[i] = 0;
    iss0.delete();
    iss1.delete();
    r_hs_last = 0;
  endtask

  // Predict this cycle's outputs from the driven inputs, then advance the model.
  task automatic model_step();
    exp_t e;
    int   g;
    int   rid;
    bit   hs;
    e = '{default: '0};
    if (rst) begin
      e.chk = 0;
      exp_q.push_back(e);
      model_reset();
      return;
    end
    g = -1;
    if (!m_pend) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && req_arvalid[i] && m_outst[i] < MAXO) g = i;
      end
    end
    rid       = int'(rid_m);
    e.chk     = 1;
    e.arready = (g >= 0) ? N'(1 << g) : '0;
    e.arvalid = m_pend;
    e.id      = 16'(m_id);
    e.addr    = m_addr;
    e.len     = m_len;
    e.rvalid  = (rid < N && rvalid_m) ? N'(1 << rid) : '0;
    e.rready  = (rid < N) ? resp_ready[rid] : 1'b1;
    e.data    = rdata_m;
    e.last    = rlast_m;
    e.err     = m_err;
    exp_q.push_back(e);

    hs = rvalid_m && e.rready;
    r_hs_last = hs;
    if (hs && (rid >= N || rresp_m != 2'b00)) m_err = 1;
    if (hs && rlast_m && rid < N) begin
      if (m_outst[rid] == 0) m_err = 1;
      else m_outst[rid]--;
    end
    if (m_pend && arready_m) begin
      if (m_id == 0) iss0.push_back(int'(m_len));
      else           iss1.push_back(int'(m_len));
      m_pend = 0;
    end
    if (g >= 0) begin
      m_outst[g]++;
      m_pend = 1;
      m_id   = g;
      m_addr = req_araddr[g*64 +: 64];
      m_len  = req_arlen[g*8 +: 8];
      m_rr   = (g + 1) % N;
      n_grants[g]++;
    end
  endtask

  // Inputs are set at posedge+1; model at posedge+2; monitor at negedge.
  task automatic cyc();
    #1 model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    resp_ready  = '0;
    arready_m   = 1'b0;
    rid_m       = '0;
    rdata_m     = '0;
    rresp_m     = '0;
    rlast_m     = 1'b0;
    rvalid_m    = 1'b0;
  endtask

  task automatic new_rdata();
    for (int i = 0; i < 16; i++) rdata_m[32*i +: 32] = $urandom();
  endtask

  // Monitor: pops one expectation per cycle and compares.
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      if (me.chk) begin
        check("req_arready", 512'(req_arready), 512'(me.arready));
        check("arvalid_m",   512'(arvalid_m),   512'(me.arvalid));
        check("arid_m",      512'(arid_m),      512'(me.id));
        check("araddr_m",    512'(araddr_m),    512'(me.addr));
        check("arlen_m",     512'(arlen_m),     512'(me.len));
        check("arsize_m",    512'(arsize_m),    512'(3'b110));
        check("resp_valid",  512'(resp_valid),  512'(me.rvalid));
        check("rready_m",    512'(rready_m),    512'(me.rready));
        check("resp_data",   resp_data,         me.data);
        check("resp_last",   512'(resp_last),   512'(me.last));
        check("err",         512'(err),         512'(me.err));
      end
    end
  end

  initial begin
    int lim;
    clear_inputs();
    rst = 1'b1;
    r_act = 0;
    for (int i = 0; i < N; i++) n_grants[i] = 0;
    model_reset();
    @(posedge clk);
    #1;
    cyc();
    cyc();
    rst = 1'b0;

    // Single request from the vertex fetcher.
    req_arvalid = 2'b01;
    req_araddr[63:0] = 64'h1000;
    req_arlen[7:0]   = 8'd0;
    arready_m = 1'b1;
    cyc();
    req_arvalid = '0;
    cyc();
    cyc();

    // Random traffic; R traffic held off at first so credits saturate.
    for (int n = 0; n < 3000; n++) begin
      if (r_hs_last && r_act) begin
        r_left--;
        if (r_left == 0) r_act = 0;
        new_rdata();
      end
      if (!r_act && n >= 300 && $urandom_range(1, 0) == 1) begin
        if (iss0.size() > 0 && (iss1.size() == 0 || $urandom_range(1, 0) == 0)) begin
          r_id = 0; r_left = iss0.pop_front() + 1; r_act = 1;
        end else if (iss1.size() > 0) begin
          r_id = 1; r_left = iss1.pop_front() + 1; r_act = 1;
        end
      end
      req_arvalid = N'($urandom());
      for (int i = 0; i < N; i++) begin
        req_araddr[64*i +: 64] = {$urandom(), $urandom()} & ~64'h3f;
        req_arlen[8*i +: 8]    = 8'($urandom_range(7, 0));
      end
      arready_m  = ($urandom_range(2, 0) != 0);
      rvalid_m   = r_act;
      rid_m      = 16'(r_id);
      rlast_m    = r_act && (r_left == 1);
      resp_ready = N'($urandom());
      cyc();
    end

    // Drain all issued bursts with bounded effort.
    req_arvalid = '0;
    lim = 0;
    while ((r_act || m_pend || iss0.size() > 0 || iss1.size() > 0) && lim < 4000) begin
      if (r_hs_last && r_act) begin
        r_left--;
        if (r_left == 0) r_act = 0;
        new_rdata();
      end
      if (!r_act) begin
        if (iss0.size() > 0) begin
          r_id = 0; r_left = iss0.pop_front() + 1; r_act = 1;
        end else if (iss1.size() > 0) begin
          r_id = 1; r_left = iss1.pop_front() + 1; r_act = 1;
        end
      end
      arready_m  = 1'b1;
      rvalid_m   = r_act;
      rid_m      = 16'(r_id);
      rlast_m    = r_act && (r_left == 1);
      resp_ready = N'($urandom());
      cyc();
      lim++;
    end
    checks++;
    if (lim >= 4000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles required under 4000", lim);
    end
    checks++;
    if (n_grants[0] == 0 || n_grants[1] == 0) begin
      errors++;
      $display("FAIL grant_coverage: got %0d/%0d required both nonzero", n_grants[0], n_grants[1]);
    end

    // Unknown id: dropped with rready_m high, err set; reset clears it.
    clear_inputs();
    r_act = 0;
    rst = 1'b1; cyc(); rst = 1'b0;
    rid_m = 16'd5; rvalid_m = 1'b1; rlast_m = 1'b1; new_rdata();
    cyc();
    clear_inputs();
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc();

    // Error response on a valid id still delivers the beat.
    rid_m = 16'd0; rvalid_m = 1'b1; rresp_m = 2'b10; resp_ready = 2'b01; new_rdata();
    cyc();
    clear_inputs();
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;

    // Last beat for a requester with no outstanding burst.
    rid_m = 16'd1; rvalid_m = 1'b1; rlast_m = 1'b1; resp_ready = 2'b10; new_rdata();
    cyc();
    clear_inputs();
    cyc();
    cyc();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
